sprite_rom_arbiter: RTL
=======================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite requesters sharing one image ROM read port.
REQ-002 Parameter ADDR_W, default 17: ROM word address width.
REQ-003 Parameter DATA_W, default 12: ROM pixel width (RGB 4:4:4).
REQ-004 Parameter ROM_LAT, default 2: fixed ROM read latency in cycles, from rom_en to rom_data valid; legal range 1..4.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 req  input  NUM_REQ  per-requester read request, level.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 gnt  output  NUM_REQ  one-hot grant pulse; marks the cycle the request is issued to the ROM.
REQ-010 rom_en  output  1  ROM read enable.
REQ-011 rom_addr  output  ADDR_W  ROM read address.
REQ-012 rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en.
REQ-013 rd_valid  output  NUM_REQ  one-hot return strobe for the owning requester.
REQ-014 rd_data  output  DATA_W  returned pixel; 12'h0 when no rd_valid bit is set.

Function
REQ-015 Arbitration point in cycle N samples req and req_addr; the winner is issued in cycle N+1 with gnt[w]=1, rom_en=1, rom_addr = req_addr of w sampled in cycle N.
REQ-016 gnt, rom_en and rom_addr are registered outputs; with no request sampled: gnt=0, rom_en=0, rom_addr holds its last value.
REQ-017 Round-robin: search starts at (last_winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0; the winner becomes lowest priority in the next arbitration.
REQ-018 Throughput: one issue per cycle; the same requester may win back-to-back when it is the only one requesting.
REQ-019 A sampled request is committed: it is issued even if req drops in cycle N+1.
REQ-020 A requester keeps req and req_addr stable until its gnt; holding req high after gnt is a new request.
REQ-021 A tag pipeline ROM_LAT deep carries the one-hot owner; rd_valid[w] = 1 and rd_data = rom_data exactly ROM_LAT cycles after gnt[w].
REQ-022 Returns are in issue order; no rd_valid bit is set without a preceding gnt; at most one bit of gnt and of rd_valid is set per cycle.
REQ-023 Simultaneous requests from all NUM_REQ requesters, held continuously, are served strictly in rotation with no requester waiting more than NUM_REQ issue cycles.

Reset
REQ-024 While rst=1: gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, tag pipeline cleared, last_winner=NUM_REQ-1 (first search starts at requester 0).
REQ-025 Reset asserted mid-operation discards all in-flight reads; no rd_valid is produced for them after release.
REQ-026 First arbitration samples in the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SPRITE_ARB_PRIO_EN defined: requester 0 (player sprite) wins whenever req[0] is sampled; the remaining requesters are served round-robin among themselves, with pointer updates only on their wins.
REQ-028 SPRITE_ARB_PRIO_EN undefined: pure round-robin over all NUM_REQ requesters per REQ-017.

Structure
REQ-029 Shared package sprite_pkg holds SPR_ADDR_W, SPR_DATA_W, SPR_NUM_REQ and SPR_ROM_LAT constants used as parameter defaults.
REQ-030 Combinational round-robin picker is a separate sub-module rr_pick (inputs: request vector, pointer; output: one-hot winner, winner index).

Verification
REQ-031 Single requester: req[2]=1, addr 17'h00123 for one cycle -> gnt[2] and rom_addr=17'h00123 one cycle later; rd_valid[2] with model data ROM_LAT cycles after gnt.
REQ-032 All four requesting continuously from reset -> gnt order 0,1,2,3,0,1,... one per cycle; rd_valid order matches, with rd_data equal to the model ROM at each address.
REQ-033 req[1] pulsed one cycle then dropped -> still granted once; no second grant.
REQ-034 rst asserted 1 cycle after gnt[3] with ROM_LAT=2 -> outputs 0 immediately; no rd_valid[3] after release; next grant with all requesting is to requester 0.
REQ-035 SPRITE_ARB_PRIO_EN defined, req=4'b1111 held -> gnt[0] every cycle; with req[0] toggling each cycle -> others alternate 1,2,3 in the gaps.
REQ-036 Idle (req=0) for 10 cycles -> rom_en, gnt and rd_valid remain 0 and rd_data=12'h0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite ROM arbiter slice, used as parameter defaults.
package sprite_pkg;

  localparam int SPR_ADDR_W  = 17;
  localparam int SPR_DATA_W  = 12;
  localparam int SPR_NUM_REQ = 4;
  localparam int SPR_ROM_LAT = 2;

  // Index width for a requester vector; never zero, even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request found after the
// pointer (wrapping) wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  always_comb begin
    int c;
    // NOTE: every output gets a default first so no path through the loop leaves a latch.
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    c       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!win_any && req[c]) begin
        win_any   = 1'b1;
        win_idx   = IDX_W'(c);
        win_oh[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite image ROM read port, with a tag
// pipeline steering returns. Define SPRITE_ARB_PRIO_EN to give requester 0 absolute priority.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = SPR_NUM_REQ,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int DATA_W  = SPR_DATA_W,
  parameter int ROM_LAT = SPR_ROM_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [IDX_W-1:0]   last_q;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] nxt_gnt;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_any;
  logic               upd_ptr;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] tag_q    [ROM_LAT];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

`ifdef SPRITE_ARB_PRIO_EN
  // Requester 0 is handled outside the rotation, so it never enters the picker.
  assign cand = {req[NUM_REQ-1:1], 1'b0};
`else
  assign cand = req;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (cand),
    .ptr    (last_q),
    .win_oh (pick_oh),
    .win_idx(pick_idx),
    .win_any(pick_any)
  );

  always_comb begin
    nxt_gnt = pick_oh;
    nxt_idx = pick_idx;
    nxt_any = pick_any;
    upd_ptr = pick_any;
`ifdef SPRITE_ARB_PRIO_EN
    if (req[0]) begin
      nxt_gnt = NUM_REQ'(1);
      nxt_idx = '0;
      nxt_any = 1'b1;
      upd_ptr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      // NOTE: the tag pipeline is reset so in-flight reads are dropped on reset; a plain data memory would not need this.
      for (int k = 0; k < ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here see pre-edge values.
      gnt    <= nxt_gnt;
      rom_en <= nxt_any;
      if (nxt_any) rom_addr <= addr_arr[nxt_idx];
      if (upd_ptr) last_q   <= nxt_idx;
      tag_q[0] <= gnt;
      for (int k = 1; k < ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // The tag leaves the pipeline in the same cycle the ROM presents its data.
  assign rd_valid = tag_q[ROM_LAT-1];
  assign rd_data  = (|rd_valid) ? rom_data : '0;

endmodule
